signed_divider: RTL and testbench



---
 rtl/signed_divider.sv | 129 ++++++++++++
 tb/tb_signed_divider.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_divider.sv
// signed_divider: restoring signed divider, one quotient bit per cycle,
// 2*WIDTH-bit dividend over WIDTH-bit divisor, valid/ready on both sides.
module signed_divider #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               src_valid,
   output logic               src_ready,
   input  logic [2*WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0]   Divisor,
   output logic               dest_valid,
   input  logic               dest_ready,
   output logic [2*WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0]   Remainder,
   output logic               div_by_zero
);
   localparam int DW = 2 * WIDTH;
   localparam int CW = $clog2(DW + 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t state, state_nx;

   logic [CW-1:0]    cnt;
   logic [DW-1:0]    dvd;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvs;
   logic             q_neg;
   logic             r_neg;
   logic             zero;

   logic [DW-1:0]    dd_mag;
   logic [WIDTH-1:0] ds_mag;
   logic             ds_zero;
   logic             last;
   logic             ge;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] rem_nx;
   logic [DW-1:0]    dvd_nx;

   assign src_ready  = (state == IDLE) && !rst;
   assign dest_valid = (state == DONE);
   assign last       = (cnt == CW'(1));

   assign dd_mag  = Dividend[DW-1] ? -Dividend : Dividend;
   assign ds_mag  = Divisor[WIDTH-1] ? -Divisor : Divisor;
   assign ds_zero = (Divisor == '0);

   // dvd holds the remaining dividend bits on top and collects quotient bits below
   always_comb begin
      rem_sh = {rem, dvd[DW-1]};
      diff   = rem_sh - {1'b0, dvs};
      ge     = !diff[WIDTH];
      rem_nx = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      dvd_nx = {dvd[DW-2:0], ge};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (src_valid) state_nx = CALC;
         CALC: if (last) state_nx = DONE;
         DONE: if (dest_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // a zero divisor skips the restoring steps: one pass through CALC, then DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         dvd         <= '0;
         rem         <= '0;
         dvs         <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         zero        <= 1'b0;
         Quotient    <= '0;
         Remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (src_valid) begin
                  q_neg <= Dividend[DW-1] ^ Divisor[WIDTH-1];
                  r_neg <= Dividend[DW-1];
                  zero  <= ds_zero;
                  dvd   <= ds_zero ? Dividend : dd_mag;
                  dvs   <= ds_mag;
                  rem   <= '0;
                  cnt   <= ds_zero ? CW'(1) : CW'(DW);
               end
            end
            CALC: begin
               cnt <= cnt - CW'(1);
               rem <= rem_nx;
               dvd <= dvd_nx;
               if (last) begin
                  if (zero) begin
                     Quotient    <= '1;
                     Remainder   <= dvd[WIDTH-1:0];
                     div_by_zero <= 1'b1;
                  end else begin
                     Quotient    <= q_neg ? -dvd_nx : dvd_nx;
                     Remainder   <= r_neg ? -rem_nx : rem_nx;
                     div_by_zero <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_signed_divider.sv
// tb_signed_divider: directed and random operands against a plain-arithmetic
// model of signed division, checked on every cycle.
module tb_signed_divider;
   localparam int W  = 16;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          src_valid = 1'b0;
   logic          dest_ready = 1'b0;
   logic [DW-1:0] Dividend = '0;
   logic [W-1:0]  Divisor = '0;
   logic          src_ready;
   logic          dest_valid;
   logic [DW-1:0] Quotient;
   logic [W-1:0]  Remainder;
   logic          div_by_zero;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   signed_divider #(.WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .src_valid(src_valid),
      .src_ready(src_ready),
      .Dividend(Dividend),
      .Divisor(Divisor),
      .dest_valid(dest_valid),
      .dest_ready(dest_ready),
      .Quotient(Quotient),
      .Remainder(Remainder),
      .div_by_zero(div_by_zero)
   );

   typedef struct packed {
      logic [DW-1:0] q;
      logic [W-1:0]  r;
      logic          z;
   } res_t;

   function automatic res_t model(input logic [DW-1:0] a, input logic [W-1:0] b);
      res_t   o;
      longint sa;
      longint sb;
      if (b == '0) begin
         o.q = '1;
         o.r = a[W-1:0];
         o.z = 1'b1;
      end else begin
         sa  = $signed(a);
         sb  = $signed(b);
         o.q = DW'(sa / sb);
         o.r = W'(sa % sb);
         o.z = 1'b0;
      end
      return o;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic expire(input string name);
      total++;
      bad++;
      $display("FAIL %s: bound expired without the expected handshake", name);
   endtask

   int   cyc = 0;
   logic started = 1'b0;
   logic busy = 1'b0;
   int   acc_cyc = 0;
   int   lat = 0;
   res_t exp_r = '0;
   res_t cur = '0;
   int   handshakes = 0;
   int   accepts = 0;
   logic exp_ready;
   logic exp_dv;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) started <= 1'b1;
   end

   // one outstanding operation at most: the model is a single slot
   always @(negedge clk) begin
      if (started) begin
         exp_ready = !rst && !busy;
         exp_dv    = busy && (cyc - acc_cyc >= lat);
         chk("src_ready", 64'(src_ready), 64'(exp_ready));
         chk("dest_valid", 64'(dest_valid), 64'(exp_dv));
         chk("quotient", 64'(Quotient), 64'(cur.q));
         chk("remainder", 64'(Remainder), 64'(cur.r));
         chk("div_by_zero", 64'(div_by_zero), 64'(cur.z));
         if (rst) begin
            busy = 1'b0;
            cur  = '0;
         end else begin
            if (busy && (cyc + 1 - acc_cyc == lat)) cur = exp_r;
            if (exp_dv && dest_ready) begin
               busy = 1'b0;
               handshakes++;
            end
            if (src_valid && exp_ready) begin
               busy    = 1'b1;
               acc_cyc = cyc + 1;
               exp_r   = model(Dividend, Divisor);
               lat     = exp_r.z ? 1 : DW;
               accepts++;
            end
         end
      end
   end

   logic rnd = 1'b0;
   int   ops = 0;

   task automatic send(input logic [DW-1:0] a, input logic [W-1:0] b);
      int n;
      n = 0;
      Dividend  = a;
      Divisor   = b;
      src_valid = 1'b1;
      @(negedge clk);
      while (!src_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!src_ready) expire("accept");
      @(posedge clk);
      #2;
      src_valid = 1'b0;
      Dividend  = $urandom;
      Divisor   = W'($urandom);
   endtask

   task automatic finish_op();
      int n;
      n = 0;
      @(negedge clk);
      while (!(dest_valid && dest_ready) && n < 500) begin
         @(posedge clk);
         #2;
         if (rnd) dest_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         n++;
      end
      if (!(dest_valid && dest_ready)) expire("result");
      ops++;
      @(posedge clk);
      #2;
   endtask

   logic [DW-1:0] t_a [9] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C,
                              32'd100100, 32'd0, 32'hFFFF_FFFF,
                              32'h8000_0000, 32'd1234};
   logic [W-1:0]  t_b [9] = '{16'd7, 16'd7, 16'hFFF9, 16'hFFF9,
                              16'hFC17, 16'hFFFF, 16'd1,
                              16'hFFFF, 16'd0};
   logic [DW-1:0] t_q [9] = '{32'd14, 32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd14,
                              32'hFFFF_FF9C, 32'd0, 32'hFFFF_FFFF,
                              32'h8000_0000, 32'hFFFF_FFFF};
   logic [W-1:0]  t_r [9] = '{16'd2, 16'hFFFE, 16'd2, 16'hFFFE,
                              16'd0, 16'd0, 16'd0,
                              16'd0, 16'd1234};
   logic          t_z [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      res_t r;
      int   sel;
      repeat (10) @(posedge clk);
      #2;
      rst        = 1'b0;
      dest_ready = 1'b1;

      for (int i = 0; i < 9; i++) begin
         r = model(t_a[i], t_b[i]);
         chk("model_q", 64'(r.q), 64'(t_q[i]));
         chk("model_r", 64'(r.r), 64'(t_r[i]));
         chk("model_z", 64'(r.z), 64'(t_z[i]));
         send(t_a[i], t_b[i]);
         finish_op();
      end

      dest_ready = 1'b0;
      send(32'd100, 16'd7);
      for (int n = 0; n < 100 && !dest_valid; n++) @(negedge clk);
      if (!dest_valid) expire("bp_valid");
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #2;
         src_valid = (k == 2);
         Dividend  = 32'd50;
         Divisor   = 16'd5;
         chk("bp_q", 64'(Quotient), 64'd14);
         chk("bp_src_ready", 64'(src_ready), 64'd0);
      end
      src_valid  = 1'b0;
      dest_ready = 1'b1;
      finish_op();

      send(32'd1000, 16'd3);
      repeat (9) @(posedge clk);
      #2;
      rst       = 1'b1;
      src_valid = 1'b1;
      Dividend  = 32'd50;
      Divisor   = 16'd5;
      @(posedge clk);
      #2;
      chk("rst_dest_valid", 64'(dest_valid), 64'd0);
      chk("rst_q", 64'(Quotient), 64'd0);
      chk("rst_r", 64'(Remainder), 64'd0);
      rst = 1'b0;
      send(32'd50, 16'd5);
      finish_op();
      chk("q_50_5", 64'(Quotient), 64'd10);
      chk("r_50_5", 64'(Remainder), 64'd0);

      rnd = 1'b1;
      for (int i = 0; i < 50; i++) begin
         sel = $urandom_range(0, 7);
         if (sel == 0) send($urandom, 16'd0);
         else if (sel < 3) send($urandom, W'($urandom_range(1, 15)));
         else if (sel == 3) send(DW'($urandom_range(0, 5000)), W'($urandom));
         else send($urandom, W'($urandom));
         finish_op();
      end
      rnd        = 1'b0;
      dest_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2;

      chk("handshakes", 64'(handshakes), 64'(ops));
      chk("accepts", 64'(accepts), 64'(ops + 1));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not end, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
